// File: rtl/store_pkg.sv
// Shared encodings and address-map constants for the memory-stage store engine.
package store_pkg;

  typedef enum logic [1:0] {
    ST_SW   = 2'b00,
    ST_SH   = 2'b01,
    ST_SB   = 2'b10,
    ST_NONE = 2'b11
  } st_type_e;

  localparam logic [31:0] DM_BASE      = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT     = 32'h0000_2FFF;
  localparam logic [31:0] TIMER0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TIMER0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] TIMER1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TIMER1_LIMIT = 32'h0000_7F1B;
  localparam logic [31:0] INTGEN_BASE  = 32'h0000_7F20;
  localparam logic [31:0] INTGEN_LIMIT = 32'h0000_7F23;

  // Timer count register is read-only from the CPU side.
  localparam logic [31:0] TIMER_COUNT_OFF = 32'd8;

  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } st_state_e;

  function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/st_lane_fmt.sv
// Byte-lane formatter: replicates store data across lanes and builds byte enables.
module st_lane_fmt
  import store_pkg::*;
(
  input  st_type_e    st_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata
);

  always_comb begin
    byte_en = 4'b0000;
    wdata   = 32'h0;
    case (st_type)
      ST_SW: begin
        byte_en = 4'b1111;
        wdata   = data;
      end
      ST_SH: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data[15:0]}};
      end
      ST_SB: begin
        byte_en = 4'b0001 << addr_lo;
        wdata   = {4{data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Memory-stage store engine: legality check, lane formatting and a req/ack write
// handshake that stalls the pipeline until the write is acknowledged or times out.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_StValid,
  input  logic [1:0]  M_StType,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_Data,
  input  logic        M_Flush,
  output logic        M_Stall,
  output logic        M_ExcAdES,
  output logic        M_BusErr,
  output logic        B_Req,
  output logic [31:0] B_Addr,
  output logic [31:0] B_WData,
  output logic [3:0]  B_ByteEn,
  input  logic        B_Ack,
  input  logic        B_Err,
  output st_state_e   dbg_state
);

  // Handshake: B_Req rises the cycle after acceptance and holds with stable
  // B_Addr/B_WData/B_ByteEn until a cycle with B_Ack high (B_Err is only
  // meaningful alongside B_Ack) or until TIMEOUT REQ cycles have elapsed.

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  st_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        bus_err_q, bus_err_d;

  st_type_e    st_type;
  logic        is_store, misaligned;
  logic        in_dm, in_t0, in_t1, in_ig, in_timer, is_count, timer_bad;
  logic [31:0] t0_off, t1_off;
  logic        accept, last_cycle;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;

  assign st_type  = st_type_e'(M_StType);
  assign is_store = M_StValid && (st_type != ST_NONE);

  assign misaligned = ((st_type == ST_SW) && (M_Addr[1:0] != 2'b00)) ||
                      ((st_type == ST_SH) && M_Addr[0]);

  assign in_dm    = in_region(M_Addr, DM_BASE, DM_LIMIT);
  assign in_t0    = in_region(M_Addr, TIMER0_BASE, TIMER0_LIMIT);
  assign in_t1    = in_region(M_Addr, TIMER1_BASE, TIMER1_LIMIT);
  assign in_ig    = in_region(M_Addr, INTGEN_BASE, INTGEN_LIMIT);
  assign in_timer = in_t0 || in_t1;

  // Word offset inside the timer block, so sub-word hits on the count word also trap.
  assign t0_off   = (M_Addr - TIMER0_BASE) & ~32'd3;
  assign t1_off   = (M_Addr - TIMER1_BASE) & ~32'd3;
  assign is_count = (in_t0 && (t0_off == TIMER_COUNT_OFF)) ||
                    (in_t1 && (t1_off == TIMER_COUNT_OFF));
  assign timer_bad = in_timer && ((st_type != ST_SW) || is_count);

  assign M_ExcAdES = is_store &&
                     (misaligned || !(in_dm || in_timer || in_ig) || timer_bad);

  assign accept     = (state_q == S_IDLE) && is_store && !M_ExcAdES && !M_Flush;
  assign last_cycle = (cnt_q == CNT_LAST);
  assign M_Stall    = accept || ((state_q == S_REQ) && !B_Ack && !last_cycle);

  st_lane_fmt u_lane_fmt (
    .st_type (st_type),
    .addr_lo (M_Addr[1:0]),
    .data    (M_Data),
    .byte_en (fmt_be),
    .wdata   (fmt_wdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = {M_Addr[31:2], 2'b00};
          wdata_d = fmt_wdata;
          be_d    = fmt_be;
          cnt_d   = 8'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Flush is deliberately not looked at here: the write is already on the bus.
        if (B_Ack) begin
          state_d   = S_IDLE;
          bus_err_d = B_Err;
        end else if (last_cycle) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign B_Req     = (state_q == S_REQ);
  assign B_Addr    = addr_q;
  assign B_WData   = wdata_q;
  assign B_ByteEn  = be_q;
  assign M_BusErr  = bus_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized stores
// compared against an address-map / lane model built from the store rules.
module tb_store_unit;
  import store_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int NO_ACK  = 99;

  logic        clk;
  logic        reset;
  logic        M_StValid;
  logic [1:0]  M_StType;
  logic [31:0] M_Addr;
  logic [31:0] M_Data;
  logic        M_Flush;
  logic        M_Stall;
  logic        M_ExcAdES;
  logic        M_BusErr;
  logic        B_Req;
  logic [31:0] B_Addr;
  logic [31:0] B_WData;
  logic [3:0]  B_ByteEn;
  logic        B_Ack;
  logic        B_Err;
  st_state_e   dbg_state;

  int tests_run = 0;
  int failed    = 0;

  store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .M_StValid (M_StValid),
    .M_StType  (M_StType),
    .M_Addr    (M_Addr),
    .M_Data    (M_Data),
    .M_Flush   (M_Flush),
    .M_Stall   (M_Stall),
    .M_ExcAdES (M_ExcAdES),
    .M_BusErr  (M_BusErr),
    .B_Req     (B_Req),
    .B_Addr    (B_Addr),
    .B_WData   (B_WData),
    .B_ByteEn  (B_ByteEn),
    .B_Ack     (B_Ack),
    .B_Err     (B_Err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access size, legal address map, lane layout
  function automatic int model_size(input logic [1:0] t);
    return (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : 1;
  endfunction

  function automatic bit model_ades(input logic [1:0] t, input logic [31:0] a);
    int  size;
    bit  dm, tmr, ig;
    int  off;
    if (t == 2'd3) return 1'b0;
    size = model_size(t);
    if ((a % size) != 0) return 1'b1;
    dm  = (a <= 32'h2FFF);
    tmr = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
    ig  = (a >= 32'h7F20 && a <= 32'h7F23);
    if (!(dm || tmr || ig)) return 1'b1;
    if (tmr && size != 4) return 1'b1;
    off = int'(a & 32'hF);
    if (tmr && (off / 4) == 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_lanes(input logic [1:0] t, input logic [31:0] a,
                                      input logic [31:0] d, output logic [3:0] be,
                                      output logic [31:0] wd);
    int size;
    size = model_size(t);
    be   = 4'(((1 << size) - 1) << a[1:0]);
    for (int k = 0; k < 4; k++) wd[8*k +: 8] = d[8*(k % size) +: 8];
  endfunction

  // Driver: one store held in M until the pipeline is released, with a given
  // ack delay (NO_ACK = never), error flag and optional flush during REQ.
  task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                          input int ack_dly, input bit err, input bit flush_req,
                          input string tag);
    bit          ades, acc, acked, tmo, exp_stall, exp_err;
    logic [3:0]  be;
    logic [31:0] wd;
    int          stalls, reqs, exp_stalls;
    ades = model_ades(t, a);
    acc  = (t != 2'd3) && !ades;
    be   = 4'b0000;
    wd   = 32'h0;
    if (acc) model_lanes(t, a, d, be, wd);

    @(posedge clk); #1;
    M_StValid = 1'b1; M_StType = t; M_Addr = a; M_Data = d;
    M_Flush = 1'b0; B_Ack = 1'b0; B_Err = 1'b0;
    @(negedge clk);
    tests_run++;
    if (M_ExcAdES !== ades) begin
      failed++; $display("FAIL %s ades: got %b want %b", tag, M_ExcAdES, ades);
    end
    tests_run++;
    if (M_Stall !== acc) begin
      failed++; $display("FAIL %s accept_stall: got %b want %b", tag, M_Stall, acc);
    end
    tests_run++;
    if (B_Req !== 1'b0) begin
      failed++; $display("FAIL %s req_in_accept: got %b want 0", tag, B_Req);
    end
    stalls = (M_Stall === 1'b1) ? 1 : 0;

    if (!acc) begin
      @(posedge clk); #1;
      M_StValid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (B_Req !== 1'b0 || M_Stall !== 1'b0) begin
        failed++; $display("FAIL %s no_req: got req=%b stall=%b want 0/0", tag, B_Req, M_Stall);
      end
      return;
    end

    acked = 1'b0; tmo = 1'b0; reqs = 0;
    for (int i = 0; i < TIMEOUT && !acked && !tmo; i++) begin
      @(posedge clk); #1;
      B_Ack   = (i == ack_dly);
      B_Err   = err && (i == ack_dly);
      M_Flush = flush_req;
      @(negedge clk);
      exp_stall = !(i == ack_dly) && (i != TIMEOUT - 1);
      if (B_Req === 1'b1) reqs++;
      if (M_Stall === 1'b1) stalls++;
      tests_run++;
      if (B_Req !== 1'b1) begin
        failed++; $display("FAIL %s req_cycle%0d: got %b want 1", tag, i, B_Req);
      end
      tests_run++;
      if (B_Addr !== (a & ~32'd3) || B_ByteEn !== be || B_WData !== wd) begin
        failed++;
        $display("FAIL %s bus_cycle%0d: got addr=%h be=%b wd=%h want addr=%h be=%b wd=%h",
                 tag, i, B_Addr, B_ByteEn, B_WData, a & ~32'd3, be, wd);
      end
      tests_run++;
      if (M_Stall !== exp_stall) begin
        failed++; $display("FAIL %s stall_cycle%0d: got %b want %b", tag, i, M_Stall, exp_stall);
      end
      acked = (i == ack_dly);
      tmo   = !acked && (i == TIMEOUT - 1);
    end

    @(posedge clk); #1;
    M_StValid = 1'b0; B_Ack = 1'b0; B_Err = 1'b0; M_Flush = 1'b0;
    @(negedge clk);
    exp_err    = (acked && err) || tmo;
    exp_stalls = acked ? 1 + ack_dly : TIMEOUT;
    tests_run++;
    if (B_Req !== 1'b0) begin
      failed++; $display("FAIL %s req_after_done: got %b want 0", tag, B_Req);
    end
    tests_run++;
    if (M_BusErr !== exp_err) begin
      failed++; $display("FAIL %s bus_err: got %b want %b", tag, M_BusErr, exp_err);
    end
    tests_run++;
    if (stalls != exp_stalls || reqs != exp_stalls) begin
      failed++;
      $display("FAIL %s cycle_counts: got stall=%0d req=%0d want stall=%0d req=%0d",
               tag, stalls, reqs, exp_stalls, exp_stalls);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (M_BusErr !== 1'b0) begin
      failed++; $display("FAIL %s bus_err_pulse: got %b want 0", tag, M_BusErr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; M_StValid = 1'b0; M_StType = 2'd0; M_Addr = 32'h0; M_Data = 32'h0;
    M_Flush = 1'b0; B_Ack = 1'b0; B_Err = 1'b0;
    #2;
    tests_run++;
    if (B_Req !== 1'b0 || B_Addr !== 32'h0 || B_WData !== 32'h0 || B_ByteEn !== 4'h0 ||
        M_BusErr !== 1'b0 || M_Stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_values: got req=%b addr=%h wd=%h be=%b err=%b stall=%b want all 0",
               B_Req, B_Addr, B_WData, B_ByteEn, M_BusErr, M_Stall);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_sw_zero_wait();
    do_store(2'd0, 32'h0000_0104, 32'h1234_5678, 0, 1'b0, 1'b0, "sw_zero_wait");
  endtask

  task automatic test_delayed_ack();
    do_store(2'd2, 32'h0000_0203, 32'h0000_00AB, 3, 1'b0, 1'b0, "sb_dly3");
    do_store(2'd1, 32'h0000_0202, 32'h0000_BEEF, 3, 1'b0, 1'b0, "sh_dly3");
  endtask

  task automatic test_ades();
    do_store(2'd1, 32'h0000_0101, 32'h1111_1111, 0, 1'b0, 1'b0, "ades_sh_misalign");
    do_store(2'd0, 32'h0000_3000, 32'h2222_2222, 0, 1'b0, 1'b0, "ades_sw_hole");
    do_store(2'd2, 32'h0000_7F04, 32'h3333_3333, 0, 1'b0, 1'b0, "ades_sb_timer");
    do_store(2'd0, 32'h0000_7F08, 32'h4444_4444, 0, 1'b0, 1'b0, "ades_sw_count");
    do_store(2'd3, 32'h0000_0100, 32'h5555_5555, 0, 1'b0, 1'b0, "reserved_type");
  endtask

  task automatic test_timeout_and_err();
    do_store(2'd0, 32'h0000_7F20, 32'hCAFE_F00D, NO_ACK, 1'b0, 1'b0, "sw_timeout");
    do_store(2'd0, 32'h0000_7F20, 32'hCAFE_F00D, 1, 1'b1, 1'b0, "sw_b_err");
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    M_StValid = 1'b1; M_StType = 2'd0; M_Addr = 32'h0000_0040; M_Data = 32'hDEAD_BEEF;
    M_Flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (M_Stall !== 1'b0 || M_ExcAdES !== 1'b0) begin
      failed++; $display("FAIL flush_idle: got stall=%b ades=%b want 0/0", M_Stall, M_ExcAdES);
    end
    @(posedge clk); #1;
    M_StValid = 1'b0; M_Flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (B_Req !== 1'b0) begin
      failed++; $display("FAIL flush_idle_req: got %b want 0", B_Req);
    end
    do_store(2'd0, 32'h0000_0080, 32'h0BAD_F00D, 2, 1'b0, 1'b1, "flush_in_req");
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    M_StValid = 1'b1; M_StType = 2'd0; M_Addr = 32'h0000_0010; M_Data = 32'h9876_5432;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (B_Req !== 1'b1) begin
      failed++; $display("FAIL mid_req_setup: got %b want 1", B_Req);
    end
    #2;
    reset = 1'b0; M_StValid = 1'b0;
    #1;
    tests_run++;
    if (B_Req !== 1'b0 || B_Addr !== 32'h0 || B_WData !== 32'h0 || B_ByteEn !== 4'h0 ||
        M_BusErr !== 1'b0 || M_Stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_req: got req=%b addr=%h wd=%h be=%b err=%b stall=%b want all 0",
               B_Req, B_Addr, B_WData, B_ByteEn, M_BusErr, M_Stall);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (B_Req !== 1'b0 || M_BusErr !== 1'b0) begin
      failed++; $display("FAIL after_reset_drop: got req=%b err=%b want 0/0", B_Req, M_BusErr);
    end
  endtask

  task automatic test_random();
    logic [1:0]  t;
    logic [31:0] a, d;
    int          dly, sel;
    bit          err, fl;
    for (int n = 0; n < 40; n++) begin
      t   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 32'($urandom_range(0, 32'h2FFF));
        1: a = 32'h7F00 + 32'($urandom_range(0, 15));
        2: a = 32'h7F10 + 32'($urandom_range(0, 15));
        3: a = 32'h7F20 + 32'($urandom_range(0, 7));
        4: a = 32'h2FF0 + 32'($urandom_range(0, 31));
        default: a = $urandom;
      endcase
      d   = $urandom;
      dly = ($urandom_range(0, 5) == 0) ? NO_ACK : $urandom_range(0, 4);
      err = 1'($urandom_range(0, 1));
      fl  = 1'($urandom_range(0, 1));
      do_store(t, a, d, dly, err, fl, $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_sw_zero_wait();
    test_delayed_ack();
    test_ades();
    test_timeout_and_err();
    test_flush();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    failed++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $fatal(1, "watchdog expired");
  end

endmodule
